a51_key_loader: RTL and testbench

//  Upstream feeder for the A5/1 keystream core. Accepts a 64-bit session key and a 22-bit

---
 rtl/a51_key_loader_if.sv | 22 ++
 rtl/a51_key_loader.sv | 170 +++++++++++++++++
 tb/tb_a51_key_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/a51_key_loader_if.sv
// Request channel into the A5/1 key loader: one session key plus frame number
// per valid/ready transfer.
interface a51_key_loader_if;
    logic        load_valid;
    logic        load_ready;
    logic [63:0] key;
    logic [21:0] frame;

    modport master (
        output load_valid,
        output key,
        output frame,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  key,
        input  frame,
        output load_ready
    );
endinterface

// File: rtl/a51_key_loader.sv
// Feeds an A5/1 keystream core: resets it, pulses startloading, shifts key then
// frame LSB first on keybit, and waits for doneloading or times out.
module a51_key_loader #(
    parameter int RST_CYCLES   = 2,
    parameter int DONE_TIMEOUT = 127
) (
    input  logic             clk,
    input  logic             rst,
    a51_key_loader_if.slave  ld,
    output logic             core_rst_n,
    output logic             startloading,
    output logic             keybit,
    input  logic             doneloading,
    output logic             key_loaded,
    output logic             load_err,
    output logic             busy
);
    localparam int WCNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [6:0]        RST_LAST   = 7'(RST_CYCLES - 1);
    localparam logic [6:0]        KEY_LAST   = 7'd63;
    localparam logic [6:0]        FRAME_LAST = 7'd21;
    localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CRST      = 3'd1,
        ST_START     = 3'd2,
        ST_KEY       = 3'd3,
        ST_FRAME     = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [63:0]       key_q, key_d;
    logic [21:0]       frame_q, frame_d;
    logic              load_ready_q, load_ready_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              startloading_q, startloading_d;
    logic              keybit_q, keybit_d;
    logic              key_loaded_q, key_loaded_d;
    logic              load_err_q, load_err_d;
    logic              busy_q, busy_d;
    logic              xfer_s;

    // Next-state sequencing and the registered-output values that follow from it
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        key_d        = key_q;
        frame_d      = frame_q;
        key_loaded_d = 1'b0;
        load_err_d   = 1'b0;
        xfer_s       = ld.load_valid && load_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_d = ST_CRST;
                    key_d   = ld.key;
                    frame_d = ld.frame;
                    cnt_d   = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_START;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_START: begin
                state_d = ST_KEY;
                cnt_d   = 7'd0;
            end
            ST_KEY: begin
                if (cnt_q == KEY_LAST) begin
                    state_d = ST_FRAME;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_FRAME: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = 7'd0;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_WAIT_DONE: begin
                // doneloading wins over a timeout that lands in the same cycle
                if (doneloading) begin
                    state_d      = ST_IDLE;
                    key_loaded_d = 1'b1;
                    wcnt_d       = '0;
                end else if (wcnt_q == WCNT_MAX) begin
                    state_d    = ST_IDLE;
                    load_err_d = 1'b1;
                    wcnt_d     = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
                wcnt_d  = '0;
            end
        endcase

        // Ready stays low for the pulse cycle so a held request lands one cycle later
        load_ready_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        busy_d         = ~load_ready_d;
        core_rst_n_d   = (state_d != ST_CRST);
        startloading_d = (state_d == ST_START);

        case (state_d)
            ST_KEY:   keybit_d = key_q[cnt_d[5:0]];
            ST_FRAME: keybit_d = frame_q[cnt_d[4:0]];
            default:  keybit_d = 1'b0;
        endcase
    end

    // State, counters, captured request and all outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 7'd0;
            wcnt_q         <= '0;
            key_q          <= 64'd0;
            frame_q        <= 22'd0;
            load_ready_q   <= 1'b0;
            core_rst_n_q   <= 1'b0;
            startloading_q <= 1'b0;
            keybit_q       <= 1'b0;
            key_loaded_q   <= 1'b0;
            load_err_q     <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wcnt_q         <= wcnt_d;
            key_q          <= key_d;
            frame_q        <= frame_d;
            load_ready_q   <= load_ready_d;
            core_rst_n_q   <= core_rst_n_d;
            startloading_q <= startloading_d;
            keybit_q       <= keybit_d;
            key_loaded_q   <= key_loaded_d;
            load_err_q     <= load_err_d;
            busy_q         <= busy_d;
        end
    end

    assign ld.load_ready  = load_ready_q;
    assign core_rst_n     = core_rst_n_q;
    assign startloading   = startloading_q;
    assign keybit         = keybit_q;
    assign key_loaded     = key_loaded_q;
    assign load_err       = load_err_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_a51_key_loader.sv
// Randomised session-level bench for a51_key_loader; expected waveforms are
// derived cycle by cycle from the session rules (reset, start, key, frame, wait).
module tb_a51_key_loader;
    localparam int RST_CYCLES   = 2;
    localparam int DONE_TIMEOUT = 127;

    logic clk;
    logic rst;
    logic core_rst_n, startloading, keybit, doneloading, key_loaded, load_err, busy;
    int   n_checks;
    int   n_errors;

    a51_key_loader_if ld_if ();

    a51_key_loader #(.RST_CYCLES(RST_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld           (ld_if),
        .core_rst_n   (core_rst_n),
        .startloading (startloading),
        .keybit       (keybit),
        .doneloading  (doneloading),
        .key_loaded   (key_loaded),
        .load_err     (load_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic rdy);
        check_eq({tag, "_ready"}, ld_if.load_ready, rdy);
        check_eq({tag, "_busy"}, busy, !rdy);
        check_eq({tag, "_crst_n"}, core_rst_n, 1'b1);
        check_eq({tag, "_start"}, startloading, 1'b0);
        check_eq({tag, "_keybit"}, keybit, 1'b0);
    endtask

    // One full session: request, core reset, start, key, frame, completion.
    task automatic run_session(input logic [63:0] k, input logic [21:0] f, input int done_at,
                               input bit noise, input int abort_at, input int busy_poke,
                               input bit expect_now, input bit hold,
                               input logic [63:0] nk, input logic [21:0] nf);
        int  n;
        int  p;
        bit  timeout;
        ld_if.load_valid = 1'b1;
        ld_if.key        = k;
        ld_if.frame      = f;
        n = 0;
        while (!ld_if.load_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_wait", (n < 300), 1'b1);
        if (expect_now) check_eq("b2b_accept_delay", n, 0);
        if (n >= 300) begin
            ld_if.load_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        ld_if.key        = {$urandom, $urandom};
        ld_if.frame      = 22'($urandom);
        for (int i = 0; i < RST_CYCLES; i++) begin
            check_eq($sformatf("crst%0d_crst_n", i), core_rst_n, 1'b0);
            check_eq($sformatf("crst%0d_ready", i), ld_if.load_ready, 1'b0);
            check_eq($sformatf("crst%0d_busy", i), busy, 1'b1);
            check_eq($sformatf("crst%0d_start", i), startloading, 1'b0);
            check_eq($sformatf("crst%0d_keybit", i), keybit, 1'b0);
            doneloading = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        check_eq("start_pulse", startloading, 1'b1);
        check_eq("start_keybit", keybit, 1'b0);
        check_eq("start_crst_n", core_rst_n, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check_eq($sformatf("key_bit%0d", i), keybit, k[i]);
            check_eq($sformatf("key%0d_start", i), startloading, 1'b0);
            check_eq($sformatf("key%0d_crst_n", i), core_rst_n, 1'b1);
            check_eq($sformatf("key%0d_pulses", i), {key_loaded, load_err}, 2'b00);
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                for (int c = 0; c < 3; c++) begin
                    check_eq("abort_crst_n", core_rst_n, 1'b0);
                    check_eq("abort_keybit", keybit, 1'b0);
                    check_eq("abort_pulses", {key_loaded, load_err, startloading}, 3'b000);
                    check_eq("abort_ready_busy", {ld_if.load_ready, busy}, 2'b01);
                    @(negedge clk);
                end
                rst = 1'b1;
                return;
            end
            ld_if.load_valid = (i == busy_poke);
            ld_if.key        = (i == busy_poke) ? 64'hFFFF_FFFF_FFFF_FFFF : ld_if.key;
            doneloading      = noise ? 1'($urandom) : doneloading;
            @(negedge clk);
        end
        ld_if.load_valid = 1'b0;
        for (int j = 0; j < 22; j++) begin
            check_eq($sformatf("frame_bit%0d", j), keybit, f[j]);
            check_eq($sformatf("frame%0d_pulses", j), {key_loaded, load_err}, 2'b00);
            doneloading = noise ? 1'($urandom) : doneloading;
            @(negedge clk);
        end
        timeout = (done_at > DONE_TIMEOUT);
        p = timeout ? DONE_TIMEOUT + 1 : done_at + 1;
        for (int c = 0; c < p; c++) begin
            doneloading = (c >= done_at);
            check_eq("wait_keybit", keybit, 1'b0);
            check_eq("wait_pulses", {key_loaded, load_err}, 2'b00);
            check_eq("wait_busy", busy, 1'b1);
            @(negedge clk);
        end
        check_eq("done_key_loaded", key_loaded, !timeout);
        check_eq("done_load_err", load_err, timeout);
        check_eq("done_ready", ld_if.load_ready, 1'b0);
        check_eq("done_keybit", keybit, 1'b0);
        if (hold) begin
            ld_if.load_valid = 1'b1;
            ld_if.key        = nk;
            ld_if.frame      = nf;
        end
        @(negedge clk);
        check_eq("after_pulses", {key_loaded, load_err}, 2'b00);
        check_idle_outputs("after", 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ka;
        logic [63:0] kb;
        logic [21:0] fa;
        logic [21:0] fb;
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b0;
        doneloading      = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.key        = 64'd0;
        ld_if.frame      = 22'd0;
        repeat (5) @(negedge clk);
        check_eq("rst_ready", ld_if.load_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_crst_n", core_rst_n, 1'b0);
        check_eq("rst_outs", {startloading, keybit, key_loaded, load_err}, 4'b0000);
        rst = 1'b1;
        #1;
        check_eq("rel_ready_early", ld_if.load_ready, 1'b0);
        @(negedge clk);
        check_idle_outputs("rel", 1'b1);

        // Nominal vector
        run_session(64'h0123_4567_89AB_CDEF, 22'h134, 60, 1'b0, -1, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        // Request during KEY must be ignored
        run_session({$urandom, $urandom}, 22'($urandom), 90, 1'b1, -1, 10, 1'b0, 1'b0, 64'd0, 22'd0);
        // Timeout, then the two completion boundaries
        run_session({$urandom, $urandom}, 22'($urandom), 1000, 1'b0, -1, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        run_session({$urandom, $urandom}, 22'($urandom), DONE_TIMEOUT, 1'b1, -1, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        run_session({$urandom, $urandom}, 22'($urandom), 0, 1'b0, -1, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        // Abort at key bit 30, then the nominal vector again
        run_session(64'h0123_4567_89AB_CDEF, 22'h134, 60, 1'b0, 30, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        run_session(64'h0123_4567_89AB_CDEF, 22'h134, 60, 1'b0, -1, -1, 1'b0, 1'b0, 64'd0, 22'd0);
        // Back-to-back with load_valid held across the completion pulse
        ka = {$urandom, $urandom};
        kb = ~ka;
        fa = 22'($urandom);
        fb = ~fa;
        run_session(ka, fa, 40, 1'b0, -1, -1, 1'b0, 1'b1, kb, fb);
        run_session(kb, fb, 50, 1'b0, -1, -1, 1'b1, 1'b0, 64'd0, 22'd0);
        for (int s = 0; s < 5; s++) begin
            run_session({$urandom, $urandom}, 22'($urandom), int'($urandom_range(0, 140)),
                        1'($urandom), -1, int'($urandom_range(0, 63)), 1'b0, 1'b0, 64'd0, 22'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
